// File: rtl/pow_unit.sv
// Sequential x^n mod 2^W by square-and-multiply, start/ready handshake.
// Define POW_UNIT_OVF_EN to add the exact overflow flag output ovf.
module pow_unit #(
    parameter int W  = 16,
    parameter int NW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  x,
    input  logic [NW-1:0] n,
    output logic          ready,
    output logic          done,
    output logic [W-1:0]  out
`ifdef POW_UNIT_OVF_EN
    ,
    output logic          ovf
`endif
);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  xr_q, xr_d;
    logic [NW-1:0] nr_q, nr_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [W-1:0]  out_q, out_d;
    logic          done_q, done_d;
    logic [W-1:0]  sq_lo, mul_lo;
    logic          nr_zero;

`ifdef POW_UNIT_OVF_EN
    logic          xo_q, xo_d;
    logic          ao_q, ao_d;
    logic          ovf_q, ovf_d;
    logic [2*W-1:0] sq_full, mul_full;
    logic          sq_hi_nz, mul_hi_nz;

    always_comb begin
        sq_full   = {{W{1'b0}}, xr_q} * {{W{1'b0}}, xr_q};
        mul_full  = {{W{1'b0}}, acc_q} * {{W{1'b0}}, xr_q};
        sq_lo     = sq_full[W-1:0];
        mul_lo    = mul_full[W-1:0];
        sq_hi_nz  = |sq_full[2*W-1:W];
        mul_hi_nz = |mul_full[2*W-1:W];
    end
`else
    // Only the low halves are needed: wrap-around modulo 2^W.
    always_comb begin
        sq_lo  = xr_q * xr_q;
        mul_lo = acc_q * xr_q;
    end
`endif

    assign nr_zero = (nr_q == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = BUSY;
            BUSY: if (nr_zero) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ready = (state_q == IDLE);
        done  = done_q;
        out   = out_q;
`ifdef POW_UNIT_OVF_EN
        ovf   = ovf_q;
`endif
    end

    always_comb begin
        xr_d   = xr_q;
        nr_d   = nr_q;
        acc_d  = acc_q;
        out_d  = out_q;
        done_d = 1'b0;
`ifdef POW_UNIT_OVF_EN
        xo_d   = xo_q;
        ao_d   = ao_q;
        ovf_d  = ovf_q;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                xr_d  = x;
                nr_d  = n;
                acc_d = W'(1);
`ifdef POW_UNIT_OVF_EN
                xo_d  = 1'b0;
                ao_d  = 1'b0;
`endif
            end
        end else begin
            unique case (1'b1)
                nr_zero: begin
                    out_d  = acc_q;
                    done_d = 1'b1;
`ifdef POW_UNIT_OVF_EN
                    ovf_d  = ao_q;
`endif
                end
                nr_q[0]: begin
                    acc_d = mul_lo;
                    nr_d  = nr_q - NW'(1);
`ifdef POW_UNIT_OVF_EN
                    ao_d  = ao_q | xo_q | mul_hi_nz;
`endif
                end
                default: begin
                    xr_d = sq_lo;
                    nr_d = nr_q >> 1;
`ifdef POW_UNIT_OVF_EN
                    xo_d = xo_q | sq_hi_nz;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xr_q   <= '0;
            nr_q   <= '0;
            acc_q  <= '0;
            out_q  <= '0;
            done_q <= 1'b0;
`ifdef POW_UNIT_OVF_EN
            xo_q   <= 1'b0;
            ao_q   <= 1'b0;
            ovf_q  <= 1'b0;
`endif
        end else begin
            xr_q   <= xr_d;
            nr_q   <= nr_d;
            acc_q  <= acc_d;
            out_q  <= out_d;
            done_q <= done_d;
`ifdef POW_UNIT_OVF_EN
            xo_q   <= xo_d;
            ao_q   <= ao_d;
            ovf_q  <= ovf_d;
`endif
        end
    end

endmodule

// File: tb/tb_pow_unit.sv
// Self-checking bench for pow_unit at W=16, NW=8.
// Checks ovf only when POW_UNIT_OVF_EN is defined.
module tb_pow_unit;

    localparam int W  = 16;
    localparam int NW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  x;
    logic [NW-1:0] n;
    logic          ready;
    logic          done;
    logic [W-1:0]  out;
`ifdef POW_UNIT_OVF_EN
    logic          ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pow_unit #(.W(W), .NW(NW)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .x     (x),
        .n     (n),
        .ready (ready),
        .done  (done),
        .out   (out)
`ifdef POW_UNIT_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic check_ovf(input string tag, input bit exp);
`ifdef POW_UNIT_OVF_EN
        check(tag, 64'(ovf), 64'(exp));
`endif
    endtask

    // True x^n is tracked with saturation at 2^W: once it reaches 2^W it
    // can only fall back to zero if x is zero, which multiplication handles.
    function automatic void model(input longint unsigned xv, input int nv,
                                  output longint unsigned res,
                                  output bit ov, output int busy);
        longint unsigned lim = 64'd1 << W;
        longint unsigned val = 1;
        res = 1;
        for (int i = 0; i < nv; i++) begin
            res = (res * xv) % lim;
            val = val * xv;
            if (val > lim) val = lim;
        end
        ov = (val >= lim);
        if (nv == 0) busy = 1;
        else busy = ($clog2(nv + 1) - 1) + $countones(nv) + 1;
    endfunction

    task automatic run_op(input logic [W-1:0] xv, input logic [NW-1:0] nv,
                          input string tag);
        longint unsigned er;
        bit eo;
        int eb;
        int g;
        int cyc;
        logic [W-1:0] held;
        model(64'(xv), int'(nv), er, eo, eb);
        g = 0;
        while (!ready && g < 100) begin
            @(posedge clk); #1; g++;
        end
        check({tag, "_idle"}, 64'(ready), 64'd1);
        x = xv;
        n = nv;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (cyc == 1) check({tag, "_rdy_low"}, 64'(ready), 64'd0);
        end while (!done && cyc < 600);
        check({tag, "_busy"}, 64'(cyc - 1), 64'(eb));
        check({tag, "_out"}, 64'(out), er);
        check_ovf({tag, "_ovf"}, eo);
        held = out;
        @(posedge clk); #1;
        check({tag, "_pulse"}, 64'(done), 64'd0);
        check({tag, "_hold"}, 64'(out), 64'(held));
    endtask

    initial begin
        int cyc;
        int dseen;
        logic [W-1:0]  rx;
        logic [NW-1:0] rn;

        rst = 1'b1;
        start = 1'b0;
        x = '0;
        n = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_done", 64'(done), 64'd0);
        check("rst_out", 64'(out), 64'd0);
        check_ovf("rst_ovf", 1'b0);
        rst = 1'b0;

        run_op(16'd3, 8'd5, "p3_5");
        run_op(16'd2, 8'd16, "p2_16");
        run_op(16'd255, 8'd2, "p255_2");
        run_op(16'd256, 8'd2, "p256_2");
        run_op(16'd7, 8'd0, "p7_0");
        run_op(16'd0, 8'd0, "p0_0");
        run_op(16'd0, 8'd200, "p0_200");
        run_op(16'd65535, 8'd255, "pm1_255");
        run_op(16'd1, 8'd255, "p1_255");

        // Back-to-back with start held high through the first done.
        x = 16'd3;
        n = 8'd5;
        start = 1'b1;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
        end while (!done && cyc < 600);
        check("b2b1_busy", 64'(cyc - 1), 64'd5);
        check("b2b1_out", 64'(out), 64'd243);
        x = 16'd2;
        n = 8'd3;
        cyc = 0;
        do begin
            @(posedge clk); #1; cyc++;
            if (cyc == 1) check("b2b2_accept", 64'(ready), 64'd0);
            if (!done) begin
                start = ~start;
                x = 16'($urandom);
                n = 8'($urandom);
            end else begin
                start = 1'b0;
            end
        end while (!done && cyc < 600);
        check("b2b2_busy", 64'(cyc - 1), 64'd4);
        check("b2b2_out", 64'(out), 64'd8);
        check_ovf("b2b2_ovf", 1'b0);
        @(posedge clk); #1;
        check("b2b_no_extra", 64'(ready), 64'd1);

        // Abort in the second busy cycle.
        x = 16'd3;
        n = 8'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_ready", 64'(ready), 64'd1);
        check("abort_out", 64'(out), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check_ovf("abort_ovf", 1'b0);
        rst = 1'b0;
        dseen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) dseen++;
        end
        check("abort_nodone", 64'(dseen), 64'd0);
        run_op(16'd5, 8'd3, "p5_3");

        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) rx = 16'($urandom_range(0, 6));
            else rx = 16'($urandom);
            rn = 8'($urandom_range(0, 255));
            if (i % 4 == 1) rn = 8'($urandom_range(0, 4));
            run_op(rx, rn, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pow_unit.md
# pow_unit

Parametrised sequential integer exponentiation unit: computes x^n mod 2^W by square-and-multiply, one operation per clock. It is the generalised successor of the team's fixed 16-bit/8-bit power block, adding configurable operand widths, a `done` pulse, defined reset values and optional exact overflow detection. It is a start/ready slave for arithmetic datapaths and is controlled by a host FSM.

## Interface
- `W`, default 16: base and result width in bits (2..32).
- `NW`, default 8: exponent width in bits (1..16).
- `clk`  in  1: clock, rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `start`  in  1: request; accepted only on an edge where `ready`=1.
- `x`  in  W: base, sampled on accept.
- `n`  in  NW: exponent, unsigned, sampled on accept.
- `ready`  out  1: unit idle; `out` holds the last result.
- `done`  out  1: one-cycle pulse on the edge a result is written.
- `out`  out  W: result x^n mod 2^W.
- `ovf`  out  1: the true x^n is at least 2^W (only present with `POW_UNIT_OVF_EN`).

## Operation
- States: IDLE (`ready`=1) and BUSY (`ready`=0).
- Internal registers: `xr[W]`, `nr[NW]`, `acc[W]`, plus `xo`/`ao` overflow flags when `POW_UNIT_OVF_EN` is defined.
- IDLE with `start`=1: `xr`<=`x`, `nr`<=`n`, `acc`<=1, `xo`<=0, `ao`<=0, go to BUSY. `out` and `ovf` keep their previous values.
- IDLE with `start`=0: hold all registers.
- BUSY with `nr`==0: `out`<=`acc`, `ovf`<=`ao`, `done`<=1, go to IDLE.
- BUSY with `nr` even and nonzero: `xr`<=low W bits of `xr*xr`; `nr`<=`nr`>>1; `xo`<=`xo` | (high W bits of `xr*xr` != 0).
- BUSY with `nr` odd: `acc`<=low W bits of `acc*xr`; `nr`<=`nr`-1; `ao`<=`ao` | `xo` | (high W bits of `acc*xr` != 0).
- Both products are full 2W-bit products; the low W bits are kept, giving wrap-around modulo 2^W.
- `start` while BUSY is ignored and not queued.
- 0^0 = 1; 0^n = 0 for n>0, and `ovf`=0 in both cases.
- Reset, including in the middle of an operation, aborts the operation. Values after reset: `ready`=1, `done`=0, `out`=0, `ovf`=0, state IDLE. Internal registers may be left undefined.

## Timing
- Accepted on edge t0. BUSY lasts S+1 cycles, where S = 0 for n=0, and S = floor(log2 n) + popcount(n) otherwise.
- On edge t0+S+1: `out`/`ovf` are updated, `done` is high for exactly one cycle, and `ready` returns to 1.
- Worst case is n = 2^NW-1: S = 2·NW-1.
- A new `start` may be accepted on the first edge where `ready`=1, i.e. the cycle in which `done` is high. This gives back-to-back operation with no idle gap.
- `out` is stable from `done` until the next completion.
- `done` is not asserted when the operation is aborted by reset.

## Configuration
- `POW_UNIT_OVF_EN` defined: the `ovf` port and the `xo`/`ao` flags exist. `ovf` is exact, i.e. set if and only if the true result is at least 2^W.
  - Exactness holds because once `xo` is set, `xr` is at least 2^W and nonzero; `acc` is then at least 1, so any later multiply by `xr` overflows.
- Not defined: no `ovf` port, no flag registers, and the high halves of the products are left unused. All other behaviour and timing are identical.

## Test plan
- W=16, NW=8: x=3, n=5 -> `ready` low for 5 cycles, `done` pulse, `out`=243, `ovf`=0.
- x=2, n=16 -> S=5, 6 busy cycles, `out`=0, `ovf`=1. Also x=255, n=2 -> 65025, `ovf`=0; x=256, n=2 -> 0, `ovf`=1.
- Boundary operands:
  - x=7, n=0 -> `out`=1 after 1 busy cycle.
  - x=0, n=0 -> 1.
  - x=0, n=200 -> 0, `ovf`=0.
  - x=65535, n=255 -> 65535 (odd power of -1 mod 2^16), `ovf`=1, 16 busy cycles.
- `start` held high continuously: the second request (x=2, n=3) is accepted in the `done` cycle of the first -> `out`=8. `start` pulses during BUSY have no effect.
- Assert `rst` on the 2nd BUSY cycle -> next cycle `ready`=1, `out`=0, `ovf`=0, no `done`. A following request x=5, n=3 -> 125.
- Randomised x and n against a reference model (modular result and exact overflow), run at W=8/NW=4 and W=32/NW=16, with the macro both defined and undefined.
